write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer.sv | 138 +++++++++++++
 tb/tb_write_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// In-order store write buffer between a cache and data memory, with load-miss address checking.
// Define WRITE_BUFFER_FWD_EN to forward data from a full-word youngest match.
module write_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic [DATA_W/8-1:0]        mem_be,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_hit,
    output logic                       rd_conflict,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BeW-1:0]    be_q   [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Byte offset within the word never participates in matching.
    logic unused_rd_lsb;
    assign unused_rd_lsb = ^rd_addr[1:0];

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(DEPTH));
    assign count     = count_q;
    assign wr_ready  = !full;
    assign mem_valid = !empty;
    assign push      = wr_valid && wr_ready;
    assign pop       = mem_valid && mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PtrW'(1);
        if (pop)  head_d = head_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            addr_q[tail_q] <= wr_addr;
            data_q[tail_q] <= wr_data;
            be_q[tail_q]   <= wr_be;
        end
    end

    // Head contents are masked while empty so stale entries never leak out.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_be   = '0;
        if (!empty) begin
            mem_addr = addr_q[head_q];
            mem_data = data_q[head_q];
            mem_be   = be_q[head_q];
        end
    end

    logic            match_any;
    logic [PtrW-1:0] idx;
`ifdef WRITE_BUFFER_FWD_EN
    logic [DATA_W-1:0] match_data;
    logic              match_full;
`endif

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        match_any  = 1'b0;
        idx        = '0;
`ifdef WRITE_BUFFER_FWD_EN
        match_data = '0;
        match_full = 1'b0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) &&
                (addr_q[idx][ADDR_W-1:2] == rd_addr[ADDR_W-1:2])) begin
                match_any  = 1'b1;
`ifdef WRITE_BUFFER_FWD_EN
                match_data = data_q[idx];
                match_full = &be_q[idx];
`endif
            end
        end
    end

`ifdef WRITE_BUFFER_FWD_EN
    assign rd_hit      = match_any && match_full;
    assign rd_conflict = match_any && !match_full;
    assign rd_data     = rd_hit ? match_data : '0;
`else
    assign rd_hit      = 1'b0;
    assign rd_conflict = match_any;
    assign rd_data     = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: stimulus queues expected memory writes, a monitor checks them.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic [31:0] rd_addr;
    logic        rd_hit;
    logic        rd_conflict;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_t;

    store_t sb[$];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_be      (mem_be),
        .rd_addr     (rd_addr),
        .rd_hit      (rd_hit),
        .rd_conflict (rd_conflict),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one store for one edge; exp_accept says whether it should be queued as a memory write.
    task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         input bit exp_accept);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = b;
        if (exp_accept) sb.push_back('{addr: a, data: d, be: b});
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && !empty; i++) tick();
        mem_ready = 1'b0;
        chk(name, 64'(empty), 64'd1);
        chk({name, "_sb"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: a write happens at the coming edge when valid and ready are both high.
    initial begin
        store_t e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected actual addr=%0h data=%0h expected none @%0t",
                             mem_addr, mem_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("mem_data", 64'(mem_data), 64'(e.data));
                    chk("mem_be",   64'(mem_be),   64'(e.be));
                end
            end
        end
    end

    initial begin
        rstn      = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        mem_ready = 1'b0;
        rd_addr   = '0;
        tick();
        tick();
        rstn = 1'b1;

        // Reset state
        chk("rst_empty",     64'(empty),       64'd1);
        chk("rst_full",      64'(full),        64'd0);
        chk("rst_count",     64'(count),       64'd0);
        chk("rst_mem_valid", 64'(mem_valid),   64'd0);
        chk("rst_wr_ready",  64'(wr_ready),    64'd1);
        chk("rst_rd_hit",    64'(rd_hit),      64'd0);
        chk("rst_rd_conf",   64'(rd_conflict), 64'd0);
        chk("rst_rd_data",   64'(rd_data),     64'd0);
        chk("rst_mem_addr",  64'(mem_addr),    64'd0);
        chk("rst_mem_data",  64'(mem_data),    64'd0);
        chk("rst_mem_be",    64'(mem_be),      64'd0);

        // Single push, one-cycle latency, stable while stalled
        offer(32'h10, 32'h11, 4'hF, 1'b1);
        chk("lat_mem_valid", 64'(mem_valid), 64'd1);
        chk("lat_mem_addr",  64'(mem_addr),  64'h10);
        chk("lat_count",     64'(count),     64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 64'(mem_valid), 64'd1);
            chk("hold_addr",  64'(mem_addr),  64'h10);
            chk("hold_data",  64'(mem_data),  64'h11);
            chk("hold_be",    64'(mem_be),    64'hF);
        end
        drain("drain1");

        // Fill, reject when full, drain in order
        for (int i = 0; i < 4; i++) offer(32'(i * 4), 32'h100 + 32'(i), 4'hF, 1'b1);
        chk("fill_full",     64'(full),     64'd1);
        chk("fill_wr_ready", 64'(wr_ready), 64'd0);
        chk("fill_count",    64'(count),    64'd4);
        offer(32'h40, 32'h55, 4'hF, 1'b0);
        chk("reject_count",  64'(count),    64'd4);
        drain("drain2");

        // Full with push+pop: pop only; then true push+pop; pointers wrap
        for (int i = 0; i < 4; i++) offer(32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 1'b1);
        mem_ready = 1'b1;
        offer(32'h200, 32'hB0, 4'hF, 1'b0);
        chk("fullpp_count", 64'(count), 64'd3);
        chk("fullpp_full",  64'(full),  64'd0);
        offer(32'h204, 32'hB1, 4'h5, 1'b1);
        chk("pp_count",     64'(count), 64'd3);
        mem_ready = 1'b0;
        chk("pp_head_addr", 64'(mem_addr), 64'h108);
        drain("drain3");

        // Forwarding: youngest full-word match wins
        offer(32'h20, 32'hAAAA, 4'hF, 1'b1);
        offer(32'h20, 32'hBBBB, 4'hF, 1'b1);
        rd_addr = 32'h22;
        #1;
`ifdef WRITE_BUFFER_FWD_EN
        chk("fwd_hit",  64'(rd_hit),      64'd1);
        chk("fwd_conf", 64'(rd_conflict), 64'd0);
        chk("fwd_data", 64'(rd_data),     64'hBBBB);
`else
        chk("fwd_hit",  64'(rd_hit),      64'd0);
        chk("fwd_conf", 64'(rd_conflict), 64'd1);
        chk("fwd_data", 64'(rd_data),     64'd0);
`endif

        // Partial byte-enable match, then no match
        offer(32'h30, 32'hCCCC, 4'h3, 1'b1);
        rd_addr = 32'h30;
        #1;
        chk("part_hit",  64'(rd_hit),      64'd0);
        chk("part_conf", 64'(rd_conflict), 64'd1);
        chk("part_data", 64'(rd_data),     64'd0);
        rd_addr = 32'h34;
        #1;
        chk("miss_hit",  64'(rd_hit),      64'd0);
        chk("miss_conf", 64'(rd_conflict), 64'd0);
        chk("miss_data", 64'(rd_data),     64'd0);
        chk("pend_count", 64'(count), 64'd3);

        // Reset mid-drain drops everything
        mem_ready = 1'b1;
        rstn      = 1'b0;
        tick();
        rstn = 1'b1;
        sb.delete();
        chk("mrst_count", 64'(count),     64'd0);
        chk("mrst_valid", 64'(mem_valid), 64'd0);
        chk("mrst_empty", 64'(empty),     64'd1);
        rd_addr = 32'h20;
        #1;
        chk("mrst_conf",  64'(rd_conflict), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("mrst_quiet", 64'(mem_valid), 64'd0);
        mem_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
